// File: rtl/seg7_capture.sv
// seg7_capture: decodes a 7-segment bus (bit0=top .. bit5=upper-left,
// bit6=middle, active-high) back into a hex digit. Each pattern must hold for
// STABLE_CYCLES consecutive enabled samples, and is then reported once through
// a valid/ready output register. If the consumer still holds an unaccepted
// report when a new one arrives, the new report is dropped and the sticky
// overrun flag is set.
module seg7_capture #(
    parameter int unsigned STABLE_CYCLES = 4,    // 1..255
    parameter bit          REPORT_BLANK  = 1'b1  // report the all-off pattern
) (
    input  logic       clk,
    input  logic       rst,        // synchronous, active-high
    input  logic       en,
    input  logic [6:0] segments,
    output logic [3:0] digit_o,
    output logic       illegal_o,
    output logic       blank_o,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       overrun_o
);

    // The stability counter only has to reach STABLE_CYCLES. It saturates
    // there and never wraps.
    localparam int unsigned     CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef struct packed {
        logic [3:0] digit;
        logic       illegal;
        logic       blank;
    } decode_t;

    // Glyph table lookup. A blank or illegal pattern decodes to digit 0.
    function automatic decode_t decode_glyph(input logic [6:0] seg);
        decode_t d;
        // NOTE: default every field before the case, so no path leaves a field unassigned.
        d = '0;
        case (seg)
            7'b0111111: d.digit = 4'h0;
            7'b0000110: d.digit = 4'h1;
            7'b1011011: d.digit = 4'h2;
            7'b1001111: d.digit = 4'h3;
            7'b1100110: d.digit = 4'h4;
            7'b1101101: d.digit = 4'h5;
            7'b1111101: d.digit = 4'h6;
            7'b0000111: d.digit = 4'h7;
            7'b1111111: d.digit = 4'h8;
            7'b1101111: d.digit = 4'h9;
            7'b1110111: d.digit = 4'hA;
            7'b1111100: d.digit = 4'hB;
            7'b0111001: d.digit = 4'hC;
            7'b1011110: d.digit = 4'hD;
            7'b1111001: d.digit = 4'hE;
            7'b1110001: d.digit = 4'hF;
            7'b0000000: d.blank   = 1'b1;
            default:    d.illegal = 1'b1;
        endcase
        return d;
    endfunction

    // Sampler state
    logic [6:0]       r_sample;
    logic [CNT_W-1:0] r_cnt;
    logic             r_armed;

    // Output register
    logic [3:0]       r_digit;
    logic             r_illegal;
    logic             r_blank;
    logic             r_valid;
    logic             r_overrun;

    // Decisions derived from the current state
    decode_t          w_decoded;
    logic             w_changed;
    logic             w_cnt_full;
    logic             w_suppress;
    logic             w_report;
    logic             w_can_load;

    // Decode the held sample, then decide whether this edge is a report event.
    always_comb begin
        w_decoded  = decode_glyph(r_sample);
        w_changed  = (segments != r_sample);
        w_cnt_full = (r_cnt == CNT_MAX);
        w_suppress = w_decoded.blank && !REPORT_BLANK;
        w_report   = r_armed && w_cnt_full && en && !w_suppress;
        w_can_load = !r_valid || out_ready;
    end

    // Sampler: track the segment bus, count identical samples, and disarm after
    // a report so that each stable pattern is reported once. Any change re-arms
    // the sampler, including a return to an earlier value. This takes priority
    // over the disarm when a change and a report fall on the same edge.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments, so every register reads pre-edge values.
        if (rst) begin
            r_sample <= '0;
            r_cnt    <= '0;
            r_armed  <= 1'b1;
        end else if (en) begin
            if (w_changed) begin
                r_sample <= segments;
                r_cnt    <= CNT_ONE;
                r_armed  <= 1'b1;
            end else begin
                if (!w_cnt_full) begin
                    r_cnt <= r_cnt + CNT_ONE;
                end
                if (w_report) begin
                    r_armed <= 1'b0;
                end
            end
        end
    end

    // Output register and handshake. A report loads when the slot is free or
    // is being accepted on this edge. Otherwise the report is dropped and the
    // overrun flag is set. With no report, an accept empties the slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_digit   <= '0;
            r_illegal <= 1'b0;
            r_blank   <= 1'b0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_report && w_can_load) begin
            r_digit   <= w_decoded.digit;
            r_illegal <= w_decoded.illegal;
            r_blank   <= w_decoded.blank;
            r_valid   <= 1'b1;
        end else if (w_report) begin
            r_overrun <= 1'b1;
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign digit_o   = r_digit;
    assign illegal_o = r_illegal;
    assign blank_o   = r_blank;
    assign out_valid = r_valid;
    assign overrun_o = r_overrun;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture (STABLE_CYCLES=4). A second instance built
// with REPORT_BLANK=0 shares the same stimulus and is used for the blank case.
// Inputs change 1 time unit after a rising edge, and outputs are checked at
// that same point.
module tb_seg7_capture;

    localparam logic [6:0] GLYPH [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [6:0] segments;
    logic       out_ready;

    logic [3:0] digit_o;
    logic       illegal_o;
    logic       blank_o;
    logic       out_valid;
    logic       overrun_o;

    logic [3:0] nb_digit;
    logic       nb_illegal;
    logic       nb_blank;
    logic       nb_valid;
    logic       nb_overrun;

    int n_tests = 0;
    int n_fail  = 0;

    seg7_capture #(.STABLE_CYCLES(4), .REPORT_BLANK(1'b1)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .segments  (segments),
        .digit_o   (digit_o),
        .illegal_o (illegal_o),
        .blank_o   (blank_o),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun_o (overrun_o)
    );

    seg7_capture #(.STABLE_CYCLES(4), .REPORT_BLANK(1'b0)) u_dut_nb (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .segments  (segments),
        .digit_o   (nb_digit),
        .illegal_o (nb_illegal),
        .blank_o   (nb_blank),
        .out_valid (nb_valid),
        .out_ready (out_ready),
        .overrun_o (nb_overrun)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        n_tests++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b1;
        out_ready = 1'b1;
        segments  = 7'b0000000;
        tick(2);
        check("rst_digit",   8'(digit_o),   8'h0);
        check("rst_illegal", 8'(illegal_o), 8'h0);
        check("rst_blank",   8'(blank_o),   8'h0);
        check("rst_valid",   8'(out_valid), 8'h0);
        check("rst_overrun", 8'(overrun_o), 8'h0);

        // 1: each glyph held 6 edges gives one pulse on the 5th edge.
        rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            segments = GLYPH[k];
            tick(4);
            check("t1_quiet",   8'(out_valid), 8'h0);
            tick(1);
            check("t1_valid",   8'(out_valid), 8'h1);
            check("t1_digit",   8'(digit_o),   8'(k));
            check("t1_illegal", 8'(illegal_o), 8'h0);
            check("t1_blank",   8'(blank_o),   8'h0);
            tick(1);
            check("t1_clear",   8'(out_valid), 8'h0);
        end

        // 2: a short 3 glitch is not reported. The 4 report comes 5 edges after the switch.
        segments = GLYPH[3];
        tick(2);
        check("t2_no3",    8'(out_valid), 8'h0);
        segments = GLYPH[4];
        tick(4);
        check("t2_quiet",  8'(out_valid), 8'h0);
        tick(1);
        check("t2_valid",  8'(out_valid), 8'h1);
        check("t2_digit",  8'(digit_o),   8'h4);
        tick(1);
        check("t2_clear",  8'(out_valid), 8'h0);

        // 3: an illegal pattern is reported. Blank is reported only where REPORT_BLANK=1.
        segments = 7'b0000001;
        tick(5);
        check("t3_ill_valid", 8'(out_valid), 8'h1);
        check("t3_ill_flag",  8'(illegal_o), 8'h1);
        check("t3_ill_digit", 8'(digit_o),   8'h0);
        check("t3_ill_blank", 8'(blank_o),   8'h0);
        tick(1);
        check("t3_ill_clear", 8'(out_valid), 8'h0);
        segments = 7'b0000000;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            check("t3_nb_quiet", 8'(nb_valid), 8'h0);
            if (i == 5) begin
                check("t3_blank_valid", 8'(out_valid), 8'h1);
                check("t3_blank_flag",  8'(blank_o),   8'h1);
                check("t3_blank_digit", 8'(digit_o),   8'h0);
            end
        end

        // 4: overrun. Report 5 is pending, so the 7 report is dropped.
        out_ready = 1'b0;
        segments  = GLYPH[5];
        tick(5);
        check("t4_valid5",   8'(out_valid), 8'h1);
        check("t4_digit5",   8'(digit_o),   8'h5);
        segments = GLYPH[7];
        tick(4);
        check("t4_ovr_pre",  8'(overrun_o), 8'h0);
        tick(2);
        check("t4_hold_dig", 8'(digit_o),   8'h5);
        check("t4_hold_val", 8'(out_valid), 8'h1);
        check("t4_overrun",  8'(overrun_o), 8'h1);
        out_ready = 1'b1;
        tick(1);
        check("t4_clear",    8'(out_valid), 8'h0);
        tick(5);
        check("t4_no7",      8'(out_valid), 8'h0);
        check("t4_sticky",   8'(overrun_o), 8'h1);

        // 5: accepting on the same edge as a new report replaces the data without overrun.
        rst       = 1'b1;
        out_ready = 1'b0;
        segments  = GLYPH[8];
        tick(1);
        check("t5_rst_ovr",  8'(overrun_o), 8'h0);
        check("t5_rst_val",  8'(out_valid), 8'h0);
        rst = 1'b0;
        tick(5);
        check("t5_valid8",   8'(out_valid), 8'h1);
        check("t5_digit8",   8'(digit_o),   8'h8);
        segments = GLYPH[9];
        tick(4);
        check("t5_still8",   8'(digit_o),   8'h8);
        out_ready = 1'b1;
        tick(1);
        check("t5_digit9",   8'(digit_o),   8'h9);
        check("t5_valid9",   8'(out_valid), 8'h1);
        check("t5_no_ovr",   8'(overrun_o), 8'h0);
        tick(1);
        check("t5_clear",    8'(out_valid), 8'h0);

        // 6: en=0 freezes the count at 2. Three enabled edges then finish it.
        out_ready = 1'b0;
        segments  = GLYPH[10];
        tick(2);
        en = 1'b0;
        tick(10);
        check("t6_frozen",   8'(out_valid), 8'h0);
        en = 1'b1;
        tick(2);
        check("t6_early",    8'(out_valid), 8'h0);
        tick(1);
        check("t6_valid",    8'(out_valid), 8'h1);
        check("t6_digit",    8'(digit_o),   8'hA);

        // rst with a report pending clears every output on the next edge.
        rst = 1'b1;
        tick(1);
        check("t6_rst_val",  8'(out_valid), 8'h0);
        check("t6_rst_dig",  8'(digit_o),   8'h0);
        check("t6_rst_ill",  8'(illegal_o), 8'h0);
        check("t6_rst_blk",  8'(blank_o),   8'h0);
        check("t6_rst_ovr",  8'(overrun_o), 8'h0);

        // After reset, a blank bus is reported 5 edges after rst drops.
        rst      = 1'b0;
        segments = 7'b0000000;
        tick(4);
        check("t6_blank_pre", 8'(out_valid), 8'h0);
        tick(1);
        check("t6_blank_val", 8'(out_valid), 8'h1);
        check("t6_blank_flg", 8'(blank_o),   8'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
